// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer
//   A first-word-fall-through FIFO that sits between one valid/ready producer
//   and one valid/ready consumer. It holds up to DEPTH words, keeps them in
//   strict order and never drops one.
//
// Ports
//   clk         : system clock; all state changes on the rising edge
//   rst         : synchronous reset, active high; empties the buffer
//   s_data      : producer payload
//   s_valid     : producer offers s_data this cycle
//   s_ready     : buffer can accept a word (not full and not in reset)
//   m_data      : head-of-buffer payload, zero while empty
//   m_valid     : head word is valid (buffer not empty)
//   m_ready     : consumer takes m_data this cycle
//   count       : number of stored words, 0..DEPTH
//   almost_full : count >= AFULL_LEVEL
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_COUNT = CW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_fire;
  logic                  rd_fire;

  // Both handshake flags come from registered state only, so there is no
  // combinational path between the producer and consumer sides.
  assign s_ready = (count_q != FULL_COUNT) && !rst;
  assign m_valid = (count_q != '0);

  // s_ready already excludes reset; the read side is gated explicitly so no
  // transfer completes on a reset cycle.
  assign wr_fire = s_valid && s_ready;
  assign rd_fire = m_valid && m_ready && !rst;

  assign m_data      = m_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_COUNT);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly PW bits wide, so DEPTH-1 + 1 wraps to 0.
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale contents are never visible
  // because m_data is forced to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
module tb_handshake_fifo_buffer;

  localparam int NA = 4;
  localparam int LA = 3;
  localparam int NB = 8;
  localparam int LB = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;

  logic        a_s_ready, a_m_valid, a_almost_full;
  logic [7:0]  a_m_data;
  logic [2:0]  a_count;
  logic        b_s_ready, b_m_valid, b_almost_full;
  logic [15:0] b_m_data;
  logic [3:0]  b_count;

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(NA), .AFULL_LEVEL(LA)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data[7:0]), .s_valid(s_valid),
    .s_ready(a_s_ready), .m_data(a_m_data), .m_valid(a_m_valid),
    .m_ready(m_ready), .count(a_count), .almost_full(a_almost_full)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(16), .DEPTH(NB), .AFULL_LEVEL(LB)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(b_s_ready), .m_data(b_m_data), .m_valid(b_m_valid),
    .m_ready(m_ready), .count(b_count), .almost_full(b_almost_full)
  );

  // Reference model: plain queues of the words each buffer should hold.
  int qa[$];
  int qb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare every output of both buffers
  // against the model, then advance the model across the rising edge.
  task automatic cycle(input logic r, input logic sv, input logic [15:0] d,
                       input logic mr, output logic a_took);
    logic ra, va, rb, vb;
    @(negedge clk);
    rst = r; s_valid = sv; s_data = d; m_ready = mr;
    #1;
    ra = !r && (qa.size() != NA);
    va = (qa.size() != 0);
    rb = !r && (qb.size() != NB);
    vb = (qb.size() != 0);
    chk("a_s_ready", a_s_ready, ra);
    chk("a_m_valid", a_m_valid, va);
    chk("a_m_data",  a_m_data,  va ? qa[0] : 0);
    chk("a_count",   a_count,   qa.size());
    chk("a_afull",   a_almost_full, qa.size() >= LA);
    chk("b_s_ready", b_s_ready, rb);
    chk("b_m_valid", b_m_valid, vb);
    chk("b_m_data",  b_m_data,  vb ? qb[0] : 0);
    chk("b_count",   b_count,   qb.size());
    chk("b_afull",   b_almost_full, qb.size() >= LB);
    $display("cyc rst=%0b sv=%0b d=%04h mr=%0b | A cnt=%0d B cnt=%0d", r, sv, d, mr,
             qa.size(), qb.size());
    a_took = sv && ra;
    @(posedge clk);
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (va && mr) void'(qa.pop_front());
      if (sv && ra) qa.push_back(int'(d[7:0]));
      if (vb && mr) void'(qb.pop_front());
      if (sv && rb) qb.push_back(int'(d));
    end
  endtask

  initial begin
    logic took;
    int   idx;

    // Reset held with a word offered: nothing may be stored.
    repeat (2) cycle(1'b1, 1'b1, 16'h00AA, 1'b0, took);

    // Fill both buffers past full with the consumer stalled.
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 16'(i * 16'h0011), 1'b0, took);
    repeat (3) cycle(1'b0, 1'b1, 16'h0099, 1'b0, took);

    // Drain in order until both are empty.
    repeat (10) cycle(1'b0, 1'b0, 16'h0000, 1'b1, took);

    // Refill, then read and write together starting from full (wraps pointers).
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 16'(16'h0A0 + i), 1'b0, took);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 16'(16'h0B0 + i), 1'b1, took);
    repeat (10) cycle(1'b0, 1'b0, 16'h0000, 1'b1, took);

    // Streaming 0x00..0x0F with toggling back-pressure; producer holds each
    // word until the small buffer accepts it.
    idx = 0;
    for (int c = 0; c < 80 && (idx < 16 || qa.size() != 0); c++) begin
      cycle(1'b0, idx < 16, 16'(idx), (c % 2) == 0, took);
      if (took) idx++;
    end
    chk("stream_all_sent", idx, 16);

    // Reset with two words buffered: they must vanish.
    repeat (20) cycle(1'b0, 1'b0, 16'h0000, 1'b1, took);
    cycle(1'b0, 1'b1, 16'h00C1, 1'b0, took);
    cycle(1'b0, 1'b1, 16'h00C2, 1'b0, took);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, took);
    repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b1, took);

    // Random traffic with occasional reset.
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 59) == 0, 1'($urandom), 16'($urandom), 1'($urandom), took);

    cycle(1'b0, 1'b0, 16'h0000, 1'b0, took);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_buffer.md
Name: handshake_fifo_buffer

Overview:
Parametrised successor to the 8-bit master/slave valid/ready handshake pair. It sits between one valid/ready producer and one valid/ready consumer and decouples them with a DEPTH-entry first-word-fall-through buffer. It also reports occupancy and an almost-full level. Data width, depth and threshold are configurable; ordering is strictly FIFO and no data is dropped.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 4, buffer entries; power of two, >=2
AFULL_LEVEL, 3, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
s_data  input  DATA_WIDTH  producer payload
s_valid  input  1  producer has valid s_data
s_ready  output  1  buffer can accept a word this cycle
m_data  output  DATA_WIDTH  head-of-buffer payload to consumer
m_valid  output  1  m_data is valid
m_ready  input  1  consumer accepts m_data this cycle
count  output  $clog2(DEPTH)+1  current number of stored words (0..DEPTH)
almost_full  output  1  count >= AFULL_LEVEL

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk.
- Reset (rst=1 at a clk edge):
  - Read and write pointers = 0, count = 0.
  - Outputs after the edge: m_valid=0, m_data=0, almost_full=0, s_ready=1.
  - While rst is high, s_ready is forced to 0.
  - Storage array is not reset.
  - Reset mid-transfer discards all stored words. No handshake completes on a cycle where rst=1.
- Handshake events:
  - Write fires when s_valid && s_ready.
  - Read fires when m_valid && m_ready.
  - A producer holding s_valid=1 with s_ready=0 keeps its word; nothing is lost.
- Ready/valid generation:
  - s_ready = (count != DEPTH) && !rst. It depends only on state: no combinational path from m_ready to s_ready.
  - m_valid = (count != 0). It depends only on state: no combinational path from s_valid to m_valid.
- Head data: m_data = mem[rd_ptr] when count != 0, else 0. m_data and m_valid hold stable while m_valid && !m_ready.
- Latency: a word written at edge N appears on m_valid/m_data after edge N when the buffer was empty. There is no same-cycle pass-through.
- Pointers:
  - Write stores at wr_ptr, then wr_ptr increments.
  - Read increments rd_ptr.
  - Both are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count update:
  - +1 on write only, -1 on read only.
  - Unchanged when both or neither fire.
  - count never exceeds DEPTH and never underflows.
- Boundary cases:
  - Full (count=DEPTH): s_ready=0, so no write even if a read fires the same cycle. After that read, count=DEPTH-1 and s_ready=1 next cycle.
  - Empty (count=0): m_valid=0, so no read. A write and m_ready=1 in the same cycle gives count=1 next cycle.
  - Simultaneous read and write at 0 < count < DEPTH: both pointers advance and count is unchanged.
- almost_full: combinational from count; it tracks count in the same cycle.
- Throughput: one word per cycle sustained when s_valid=m_ready=1 and 0 < count < DEPTH.

Test Plan:
- Reset check: rst=1 for 2 cycles with s_valid=1, s_data=8'hAA -> s_ready=0 during reset; after release m_valid=0, m_data=0, count=0, almost_full=0, s_ready=1; no word stored.
- Fill to full: m_ready=0, write 8'h11,8'h22,8'h33,8'h44 on consecutive cycles -> count 1,2,3,4; almost_full rises when count=3; s_ready=0 at count=4; a 5th word 8'h55 held on s_data is not stored while s_ready=0.
- Drain in order: from that full state set m_ready=1 -> m_data sequence 11,22,33,44 on consecutive cycles; m_valid=0 and m_data=0 after the 4th read; count returns to 0.
- Full with simultaneous activity: at count=4, s_valid=1 and m_ready=1 -> only the read fires (count=3); the next cycle both fire and count stays 3; FIFO order is preserved across pointer wrap.
- Streaming with back-pressure: 16 incrementing bytes 8'h00..8'h0F with m_ready toggling 1,0,1,0 -> all 16 bytes received exactly once in order; m_data is stable during every m_valid && !m_ready cycle.
- Reset mid-operation plus parameter sweep: with count=2, assert rst for 1 cycle -> count=0, m_valid=0 and the old data never appears; repeat the fill/drain scenarios with DATA_WIDTH=16, DEPTH=8, AFULL_LEVEL=6 -> almost_full rises at 6, s_ready falls at 8.
